// File: rtl/param_cache_controller.sv
// Set-associative write-back/write-allocate cache controller, true-LRU, word-serial memory port.
// Define CACHE_STATS_EN to add the hit_count/miss_count outputs.
module param_cache_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned WAY_BITS  = $clog2(WAYS);
  localparam int unsigned WORD_BITS = $clog2(WORDS);
  localparam int unsigned SET_BITS  = $clog2(SETS);
  localparam int unsigned TAG_W     = ADDR_W - 2 - WORD_BITS - SET_BITS;

  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StRefill, StRespond} state_e;

  // Line storage
  logic                valid_q [SETS][WAYS];
  logic                dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [WAY_BITS-1:0] age_q   [SETS][WAYS];
  logic [DATA_W-1:0]   line_q  [SETS][WAYS][WORDS];

  state_e              state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WAY_BITS-1:0] way_q, way_d;
  logic [WORD_BITS-1:0] beat_q, beat_d;
  logic                hit_flag_q, hit_flag_d;

  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                ready_q, ready_d;
  logic                hit_q, hit_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [SET_BITS-1:0]  req_set;
  logic [WORD_BITS-1:0] req_word;
  logic [TAG_W-1:0]     req_tag;
  logic                 unused_byte_bits;

  assign req_set          = addr_q[2+WORD_BITS +: SET_BITS];
  assign req_word         = addr_q[2 +: WORD_BITS];
  assign req_tag          = addr_q[ADDR_W-1 -: TAG_W];
  assign unused_byte_bits = ^addr_q[1:0];

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]     t,
                                                  input logic [SET_BITS-1:0]  s,
                                                  input logic [WORD_BITS-1:0] k);
    return {t, s, k, 2'b00};
  endfunction

  // Tag compare and victim selection over the addressed set
  logic                hit_any;
  logic [WAY_BITS-1:0] hit_way, inv_way, old_way, victim;
  logic                has_inv;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    old_way = '0;
    // Descending scan so the lowest-index invalid way wins
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_BITS'(w);
      end
      if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (age_q[req_set][w] == WAY_BITS'(WAYS - 1)) old_way = WAY_BITS'(w);
    end
    victim = has_inv ? inv_way : old_way;
  end

  // Storage write controls
  logic                 word_we, merge_we, fill_we, dirty_set, dirty_clr, lru_touch;
  logic [WAY_BITS-1:0]  acc_way;
  logic [WORD_BITS-1:0] word_sel, beat_nxt;
  logic [DATA_W-1:0]    word_val;
  logic                 last_beat;

  assign beat_nxt  = beat_q + WORD_BITS'(1);
  assign last_beat = (beat_q == WORD_BITS'(WORDS - 1));

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    way_d       = way_q;
    beat_d      = beat_q;
    hit_flag_d  = hit_flag_q;
    data_out_d  = data_out_q;
    ready_d     = 1'b0;
    hit_d       = hit_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    acc_way     = way_q;
    word_we     = 1'b0;
    word_sel    = req_word;
    word_val    = wdata_q;
    merge_we    = 1'b0;
    fill_we     = 1'b0;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    lru_touch   = 1'b0;
`ifdef CACHE_STATS_EN
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
          rw_d    = rw;
          addr_d  = address;
          wdata_d = data_in;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit_any) begin
          acc_way    = hit_way;
          way_d      = hit_way;
          hit_flag_d = 1'b1;
          word_we    = rw_q;
          dirty_set  = rw_q;
          lru_touch  = 1'b1;
          state_d    = StRespond;
        end else begin
          way_d      = victim;
          hit_flag_d = 1'b0;
          beat_d     = '0;
          mem_req_d  = 1'b1;
          if (dirty_q[req_set][victim]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = beat_addr(tag_q[req_set][victim], req_set, '0);
            mem_wdata_d = line_q[req_set][victim][0];
            state_d     = StWriteback;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = beat_addr(req_tag, req_set, '0);
            state_d    = StRefill;
          end
        end
      end
      StWriteback: begin
        if (mem_ack) begin
          if (last_beat) begin
            dirty_clr  = 1'b1;
            beat_d     = '0;
            mem_we_d   = 1'b0;
            mem_addr_d = beat_addr(req_tag, req_set, '0);
            state_d    = StRefill;
          end else begin
            beat_d      = beat_nxt;
            mem_addr_d  = beat_addr(tag_q[req_set][way_q], req_set, beat_nxt);
            mem_wdata_d = line_q[req_set][way_q][beat_nxt];
          end
        end
      end
      StRefill: begin
        if (mem_ack) begin
          word_we  = 1'b1;
          word_sel = beat_q;
          word_val = mem_rdata;
          if (last_beat) begin
            fill_we   = 1'b1;
            merge_we  = rw_q;
            lru_touch = 1'b1;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            state_d   = StRespond;
          end else begin
            beat_d     = beat_nxt;
            mem_addr_d = beat_addr(req_tag, req_set, beat_nxt);
          end
        end
      end
      StRespond: begin
        ready_d    = 1'b1;
        hit_d      = hit_flag_q;
        data_out_d = line_q[req_set][way_q][req_word];
`ifdef CACHE_STATS_EN
        if (hit_flag_q) hit_cnt_d = hit_cnt_q + 32'd1;
        else            miss_cnt_d = miss_cnt_q + 32'd1;
`endif
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      way_q       <= '0;
      beat_q      <= '0;
      hit_flag_q  <= 1'b0;
      data_out_q  <= '0;
      ready_q     <= 1'b0;
      hit_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      way_q       <= way_d;
      beat_q      <= beat_d;
      hit_flag_q  <= hit_flag_d;
      data_out_q  <= data_out_d;
      ready_q     <= ready_d;
      hit_q       <= hit_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef CACHE_STATS_EN
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  // Line metadata; a reset mid-refill leaves every line invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_BITS'(w);
        end
      end
    end else begin
      if (dirty_set) dirty_q[req_set][acc_way] <= 1'b1;
      if (dirty_clr) dirty_q[req_set][way_q] <= 1'b0;
      if (fill_we) begin
        valid_q[req_set][way_q] <= 1'b1;
        tag_q[req_set][way_q]   <= req_tag;
        dirty_q[req_set][way_q] <= merge_we;
      end
      if (lru_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_BITS'(w) == acc_way) begin
            age_q[req_set][w] <= '0;
          end else if (age_q[req_set][w] < age_q[req_set][acc_way]) begin
            age_q[req_set][w] <= age_q[req_set][w] + WAY_BITS'(1);
          end
        end
      end
    end
  end

  // Data array; the write merge is issued after the refill beat so it wins on the same word
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (word_we)  line_q[req_set][acc_way][word_sel] <= word_val;
      if (merge_we) line_q[req_set][way_q][req_word]   <= wdata_q;
    end
  end

  assign data_out  = data_out_q;
  assign ready     = ready_q;
  assign hit       = hit_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
